// File: rtl/mem_ss_cal_pkg.sv
// Shared types for the mem_ss reset/calibration sequencer and its CSR view.
package mem_ss_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_WAIT_CAL,
    ST_STABLE,
    ST_DONE
  } t_cal_state;

  localparam int RETRY_W = 2;

  typedef struct packed {
    logic               pass;
    logic               err_timeout;
    logic               err_calfail;
    logic [RETRY_W-1:0] retry_cnt;
  } t_cal_result;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_ss_cal_timer.sv
// Loadable up-counter that stops at its terminal count and flags it.
module mem_ss_cal_timer #(
  parameter int WIDTH = 8,
  parameter int TC    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_reg;

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == WIDTH'(TC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_ss_cal_seq.sv
// mem_ss reset/calibration sequencer: reset handshake, stable-calibration
// qualification over a channel mask, per-phase timeout and bounded retry.
module mem_ss_cal_seq
  import mem_ss_cal_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = 2**20-1,
  parameter int STABLE_CYC  = 3,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              mem_rst_req,
  input  logic              mem_rst_ack_n,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_timeout,
  output logic              err_calfail,
  output logic [1:0]        retry_cnt,
  output logic [NUM_CH-1:0] cal_status
);

  localparam int PH_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ST_W = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'((RST_CYC > 0) ? RST_CYC - 1 : 0);

  t_cal_state        state_reg, state_next;
  logic [NUM_CH-1:0] mask_reg, mask_next;
  t_cal_result       result_reg, result_next;
  logic              mem_rst_req_reg, mem_rst_req_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [NUM_CH-1:0] cal_status_reg, cal_status_next;

  logic [PH_W-1:0] ph_cnt;
  logic            ph_tc, ph_load, ph_en;
  logic [ST_W-1:0] st_cnt, st_load_val;
  logic            st_tc, st_load, st_en;
  logic            in_cal, masked_ok, fail_evt, to_evt, hold_ok, retry_now;
  logic            unused_st_cnt;

  assign in_cal    = (state_reg == ST_WAIT_CAL) || (state_reg == ST_STABLE);
  assign masked_ok = ((cal_success & mask_reg) == mask_reg);
  assign fail_evt  = in_cal && |(cal_fail & mask_reg);
  assign to_evt    = ((state_reg == ST_RST_ASSERT) || in_cal) && ph_tc;
  // Hold time only counts cycles where the request is actually driven high.
  assign hold_ok   = mem_rst_req_reg && !mem_rst_ack_n && (ph_cnt >= HOLD_LAST);
  assign ph_en     = (state_reg == ST_RST_ASSERT) ? mem_rst_req_reg : in_cal;
  // Only the terminal flag of the stable counter drives decisions.
  assign unused_st_cnt = ^st_cnt;

  mem_ss_cal_timer #(.WIDTH(PH_W), .TC(TIMEOUT_CYC)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val ('0),
    .en       (ph_en),
    .cnt      (ph_cnt),
    .tc       (ph_tc)
  );

  mem_ss_cal_timer #(.WIDTH(ST_W), .TC(STABLE_CYC)) u_stable_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (st_load),
    .load_val (st_load_val),
    .en       (st_en),
    .cnt      (st_cnt),
    .tc       (st_tc)
  );

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    result_next = result_reg;
    ph_load     = 1'b0;
    st_load     = 1'b0;
    st_load_val = '0;
    st_en       = 1'b0;
    retry_now   = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_next   = ch_mask;
          result_next = '0;
          if (ch_mask == '0) begin
            state_next       = ST_DONE;
            result_next.pass = 1'b1;
          end else begin
            state_next = ST_RST_ASSERT;
            ph_load    = 1'b1;
          end
        end
      end
      ST_RST_ASSERT: begin
        if (hold_ok) begin
          state_next = ST_WAIT_CAL;
          ph_load    = 1'b1;
        end
      end
      ST_WAIT_CAL: begin
        if (masked_ok) begin
          state_next  = ST_STABLE;
          st_load     = 1'b1;
          st_load_val = ST_W'(1);
        end
      end
      ST_STABLE: begin
        if (!masked_ok) begin
          state_next = ST_WAIT_CAL;
          st_load    = 1'b1;
        end else if (st_tc) begin
          state_next       = ST_DONE;
          result_next.pass = 1'b1;
        end else begin
          st_en = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Failure/timeout overrides any normal progression in the same cycle.
    if (fail_evt || to_evt) begin
      st_load     = 1'b1;
      st_load_val = '0;
      st_en       = 1'b0;
      if (int'(result_reg.retry_cnt) < MAX_RETRY) begin
        retry_now             = 1'b1;
        result_next.retry_cnt = sat_inc(result_reg.retry_cnt);
        state_next            = ST_RST_ASSERT;
        ph_load               = 1'b1;
      end else begin
        state_next              = ST_DONE;
        result_next.pass        = 1'b0;
        result_next.err_timeout = to_evt;
        result_next.err_calfail = fail_evt;
      end
    end
  end

  // A retry drops the request for one cycle so the mem_ss sees a fresh pulse.
  assign mem_rst_req_next = (state_next == ST_RST_ASSERT) && !retry_now;
  assign busy_next        = (state_next == ST_RST_ASSERT) || (state_next == ST_WAIT_CAL) ||
                            (state_next == ST_STABLE);
  assign done_next        = (state_next == ST_DONE);
  assign cal_status_next  = ((state_next == ST_WAIT_CAL) || (state_next == ST_STABLE) ||
                             (state_next == ST_DONE)) ? (cal_success & mask_next) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      mask_reg        <= '0;
      result_reg      <= '0;
      mem_rst_req_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cal_status_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      mask_reg        <= mask_next;
      result_reg      <= result_next;
      mem_rst_req_reg <= mem_rst_req_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      cal_status_reg  <= cal_status_next;
    end
  end

  assign mem_rst_req = mem_rst_req_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign pass        = result_reg.pass;
  assign err_timeout = result_reg.err_timeout;
  assign err_calfail = result_reg.err_calfail;
  assign retry_cnt   = result_reg.retry_cnt;
  assign cal_status  = cal_status_reg;

endmodule
